// File: rtl/id_ex_hazard_stage.sv
// id_ex_hazard_stage: ID/EX pipeline register with load-use stall control.
//   Latency: decode fields appear on the E outputs one cycle after capture.
//   Backpressure: StallF/StallD hold fetch/decode while E is fed LOAD_STALL bubbles.
//
// Ports:
//   clk, rst                   rising-edge clock, asynchronous active-high reset
//   RegS1D/RegS2D/WriteRegD    decode-stage register identifiers
//   RegWD/MemReadD/ValidD      decode-stage control bits
//   FlushE                     taken branch/jump in execute; kills the decode slot
//   RegS1E/RegS2E/WriteRegE    registered identifiers for the forwarding unit
//   RegWE/MemReadE/ValidE      registered control bits
//   StallF/StallD              hold PC and IF/ID register (combinational)
//   BubbleE                    E currently holds an injected bubble
//   stall_cycles               saturating count of stalled cycles
//                              (present only when HAZARD_STATS_EN is defined)
//
// Parameters: WIDTH (identifier width), LOAD_STALL (bubbles per hazard, 1..7).

module id_ex_hazard_stage #(
  parameter int WIDTH      = 5,
  parameter int LOAD_STALL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] RegS1D,
  input  logic [WIDTH-1:0] RegS2D,
  input  logic [WIDTH-1:0] WriteRegD,
  input  logic             RegWD,
  input  logic             MemReadD,
  input  logic             ValidD,
  input  logic             FlushE,
  output logic [WIDTH-1:0] RegS1E,
  output logic [WIDTH-1:0] RegS2E,
  output logic [WIDTH-1:0] WriteRegE,
  output logic             RegWE,
  output logic             MemReadE,
  output logic             ValidE,
  output logic             StallF,
  output logic             StallD,
  output logic             BubbleE
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]      stall_cycles
`endif
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Remaining HOLD cycles after the first (detecting) stall cycle.
  localparam logic [2:0] HOLD_INIT = 3'(LOAD_STALL - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] wr_q, wr_d;
  logic             regw_q, regw_d;
  logic             memrd_q, memrd_d;
  logic             valid_q, valid_d;
  logic             bubble_q, bubble_d;

  logic hz;
  logic stall;
  logic load_bubble;

  // A load already in E whose destination is read by the decode instruction
  // cannot be forwarded in time. Register 0 is hardwired, so never a hazard.
  assign hz = ValidD & valid_q & memrd_q & regw_q & (wr_q != '0) &
              ((RegS1D == wr_q) | (RegS2D == wr_q));

  // Next-state and stall decision. A flush wins over any stall: the decode
  // instruction is dead, so holding it would only waste cycles.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall       = 1'b0;
    load_bubble = 1'b0;

    if (FlushE) begin
      state_d     = RUN;
      cnt_d       = 3'd0;
      load_bubble = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (hz) begin
            stall       = 1'b1;
            load_bubble = 1'b1;
            if (LOAD_STALL > 1) begin
              state_d = HOLD;
              cnt_d   = HOLD_INIT;
            end
          end
        end
        HOLD: begin
          // E holds a bubble here, so hz is necessarily 0: no nested hazard.
          stall       = 1'b1;
          load_bubble = 1'b1;
          cnt_d       = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  // Execute-register next values: either the decode fields or an all-zero
  // bubble marked as such.
  always_comb begin
    s1_d     = RegS1D;
    s2_d     = RegS2D;
    wr_d     = WriteRegD;
    regw_d   = RegWD;
    memrd_d  = MemReadD;
    valid_d  = ValidD;
    bubble_d = 1'b0;
    if (load_bubble) begin
      s1_d     = '0;
      s2_d     = '0;
      wr_d     = '0;
      regw_d   = 1'b0;
      memrd_d  = 1'b0;
      valid_d  = 1'b0;
      bubble_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      cnt_q    <= 3'd0;
      s1_q     <= '0;
      s2_q     <= '0;
      wr_q     <= '0;
      regw_q   <= 1'b0;
      memrd_q  <= 1'b0;
      valid_q  <= 1'b0;
      bubble_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      wr_q     <= wr_d;
      regw_q   <= regw_d;
      memrd_q  <= memrd_d;
      valid_q  <= valid_d;
      bubble_q <= bubble_d;
    end
  end

  // Stalls are gated by rst so upstream never sees a hold while in reset.
  assign StallF    = stall & ~rst;
  assign StallD    = stall & ~rst;

  assign RegS1E    = s1_q;
  assign RegS2E    = s2_q;
  assign WriteRegE = wr_q;
  assign RegWE     = regw_q;
  assign MemReadE  = memrd_q;
  assign ValidE    = valid_q;
  assign BubbleE   = bubble_q;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (StallD && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule
